ex_branch_resolve: RTL and testbench

Execute-stage back end that sits directly downstream of the ALU and registers its outputs into the EX/MEM pipeline boundary. It resolves conditional branches, JAL and JALR from the ALU compare flags and result, and checks the outcome against the fetch-stage prediction. On a mispredict it issues a one-cycle redirect and squashes the following wrong-path instruction. It also drives the branch-predictor update port.

---
 rtl/ex_branch_resolve.sv | 183 ++++++++++++++++++
 tb/tb_ex_branch_resolve.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_branch_resolve.sv
// Execute-stage back end: resolves branches/JAL/JALR, registers EX/MEM outputs,
// redirects fetch on mispredict and squashes one wrong-path instruction.
// Optional macro BR_PERF_CNT_EN adds saturating branch/mispredict counters.
module ex_branch_resolve #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  input  logic [RD_W-1:0] ex_rd_i,
  input  logic            ex_wb_en_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  input  logic            alu_lt_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic [RD_W-1:0] mem_rd_o,
  output logic            mem_wb_en_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            bp_upd_valid_o,
  output logic [XLEN-1:0] bp_upd_pc_o,
  output logic            bp_upd_taken_o,
  output logic [XLEN-1:0] bp_upd_target_o
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt_o,
  output logic [31:0]     perf_mispred_cnt_o
`endif
);

  typedef enum logic [0:0] {IDLE, SQUASH} state_t;

  state_t            r_state;
  logic              r_mem_valid;
  logic [XLEN-1:0]   r_mem_result;
  logic [RD_W-1:0]   r_mem_rd;
  logic              r_mem_wb_en;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_bp_upd_valid;
  logic [XLEN-1:0]   r_bp_upd_pc;
  logic              r_bp_upd_taken;
  logic [XLEN-1:0]   r_bp_upd_target;

  logic              w_accept;
  logic              w_is_cf;
  logic              w_cond_taken;
  logic              w_taken;
  logic              w_is_link;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_br_target;
  logic [XLEN-1:0]   w_jalr_target;
  logic [XLEN-1:0]   w_taken_target;
  logic [XLEN-1:0]   w_next_pc;
  logic              w_mispredict;
  logic              w_resolve;

  assign w_accept   = ex_valid_i & ~stall_i & ~flush_i;
  assign w_is_link  = ex_is_jal_i | ex_is_jalr_i;
  assign w_is_cf    = ex_is_branch_i | w_is_link;
  assign w_resolve  = w_accept & (r_state == IDLE);

  // Condition decode; 010/011 are not valid branch codes and resolve not taken.
  always_comb begin
    w_cond_taken = 1'b0;
    case (ex_funct3_i)
      3'b000:          w_cond_taken = alu_zero_i;
      3'b001:          w_cond_taken = ~alu_zero_i;
      3'b100, 3'b110:  w_cond_taken = alu_lt_i;
      3'b101, 3'b111:  w_cond_taken = ~alu_lt_i;
      default:         w_cond_taken = 1'b0;
    endcase
  end

  assign w_taken        = w_is_link | (ex_is_branch_i & w_cond_taken);
  assign w_pc_plus4     = ex_pc_i + XLEN'(4);
  assign w_br_target    = ex_pc_i + ex_imm_i;
  assign w_jalr_target  = {alu_result_i[XLEN-1:1], 1'b0};
  assign w_taken_target = ex_is_jalr_i ? w_jalr_target : w_br_target;
  assign w_next_pc      = w_taken ? w_taken_target : w_pc_plus4;
  assign w_mispredict   = w_is_cf & ((w_taken != ex_pred_taken_i) |
                                     (w_taken & (w_taken_target != ex_pred_target_i)));

  // EX/MEM boundary and redirect/squash control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_mem_valid     <= 1'b0;
      r_mem_result    <= '0;
      r_mem_rd        <= '0;
      r_mem_wb_en     <= 1'b0;
      r_redirect      <= 1'b0;
      r_redirect_pc   <= '0;
      r_bp_upd_valid  <= 1'b0;
      r_bp_upd_pc     <= '0;
      r_bp_upd_taken  <= 1'b0;
      r_bp_upd_target <= '0;
    end else if (flush_i) begin
      r_state        <= IDLE;
      r_mem_valid    <= 1'b0;
      r_mem_wb_en    <= 1'b0;
      r_redirect     <= 1'b0;
      r_bp_upd_valid <= 1'b0;
    end else if (stall_i) begin
      r_redirect     <= 1'b0;
      r_bp_upd_valid <= 1'b0;
    end else if (r_state == SQUASH) begin
      // Wrong-path slot: drop it; stay until an instruction is actually consumed.
      r_mem_valid    <= 1'b0;
      r_mem_wb_en    <= 1'b0;
      r_redirect     <= 1'b0;
      r_bp_upd_valid <= 1'b0;
      if (ex_valid_i) r_state <= IDLE;
    end else begin
      r_mem_valid    <= ex_valid_i;
      r_mem_wb_en    <= ex_valid_i & ex_wb_en_i;
      r_redirect     <= 1'b0;
      r_bp_upd_valid <= 1'b0;
      if (ex_valid_i) begin
        r_mem_result <= w_is_link ? w_pc_plus4 : alu_result_i;
        r_mem_rd     <= ex_rd_i;
        if (w_is_cf) begin
          r_bp_upd_valid  <= 1'b1;
          r_bp_upd_pc     <= ex_pc_i;
          r_bp_upd_taken  <= w_taken;
          r_bp_upd_target <= w_next_pc;
        end
        if (w_mispredict) begin
          r_redirect    <= 1'b1;
          r_redirect_pc <= w_next_pc;
          r_state       <= SQUASH;
        end
      end
    end
  end

`ifdef BR_PERF_CNT_EN
  logic [31:0] r_perf_br_cnt;
  logic [31:0] r_perf_mispred_cnt;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_br_cnt      <= '0;
      r_perf_mispred_cnt <= '0;
    end else begin
      if (w_resolve & w_is_cf & (r_perf_br_cnt != 32'hFFFF_FFFF))
        r_perf_br_cnt <= r_perf_br_cnt + 32'd1;
      if (w_resolve & w_mispredict & (r_perf_mispred_cnt != 32'hFFFF_FFFF))
        r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
    end
  end

  assign perf_br_cnt_o      = r_perf_br_cnt;
  assign perf_mispred_cnt_o = r_perf_mispred_cnt;
`endif

  assign ex_ready_o      = ~stall_i;
  assign mem_valid_o     = r_mem_valid;
  assign mem_result_o    = r_mem_result;
  assign mem_rd_o        = r_mem_rd;
  assign mem_wb_en_o     = r_mem_wb_en;
  assign redirect_o      = r_redirect;
  assign redirect_pc_o   = r_redirect_pc;
  assign bp_upd_valid_o  = r_bp_upd_valid;
  assign bp_upd_pc_o     = r_bp_upd_pc;
  assign bp_upd_taken_o  = r_bp_upd_taken;
  assign bp_upd_target_o = r_bp_upd_target;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed self-checking bench for ex_branch_resolve.
module tb_ex_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_lt;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd;
  logic        mem_wb_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bp_upd_valid;
  logic [31:0] bp_upd_pc;
  logic        bp_upd_taken;
  logic [31:0] bp_upd_target;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mispred_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  ex_branch_resolve #(.XLEN(32), .RD_W(5)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ex_valid_i       (ex_valid),
    .ex_ready_o       (ex_ready),
    .ex_pc_i          (ex_pc),
    .ex_imm_i         (ex_imm),
    .ex_is_branch_i   (ex_is_branch),
    .ex_is_jal_i      (ex_is_jal),
    .ex_is_jalr_i     (ex_is_jalr),
    .ex_funct3_i      (ex_funct3),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .ex_rd_i          (ex_rd),
    .ex_wb_en_i       (ex_wb_en),
    .alu_result_i     (alu_result),
    .alu_zero_i       (alu_zero),
    .alu_lt_i         (alu_lt),
    .stall_i          (stall),
    .flush_i          (flush),
    .mem_valid_o      (mem_valid),
    .mem_result_o     (mem_result),
    .mem_rd_o         (mem_rd),
    .mem_wb_en_o      (mem_wb_en),
    .redirect_o       (redirect),
    .redirect_pc_o    (redirect_pc),
    .bp_upd_valid_o   (bp_upd_valid),
    .bp_upd_pc_o      (bp_upd_pc),
    .bp_upd_taken_o   (bp_upd_taken),
    .bp_upd_target_o  (bp_upd_target)
`ifdef BR_PERF_CNT_EN
    ,
    .perf_br_cnt_o      (perf_br_cnt),
    .perf_mispred_cnt_o (perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_funct3 = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    ex_rd = '0; ex_wb_en = 1'b0; alu_result = '0; alu_zero = 1'b0; alu_lt = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                       input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic pt, input logic [31:0] ptgt,
                       input logic [4:0] rd, input logic wb, input logic [31:0] res,
                       input logic z, input logic lt);
    ex_valid = 1'b1; ex_pc = pc; ex_imm = imm; ex_is_branch = br; ex_is_jal = jal;
    ex_is_jalr = jalr; ex_funct3 = f3; ex_pred_taken = pt; ex_pred_target = ptgt;
    ex_rd = rd; ex_wb_en = wb; alu_result = res; alu_zero = z; alu_lt = lt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble();
    #12;
    n_total++;
    if ({mem_valid, mem_wb_en, redirect, bp_upd_valid, bp_upd_taken} !== 5'b0 ||
        mem_result !== 32'h0 || redirect_pc !== 32'h0 || bp_upd_target !== 32'h0)
      $display("FAIL reset_outputs: got v=%b r=%b bp=%b res=%h rpc=%h", mem_valid, redirect,
               bp_upd_valid, mem_result, redirect_pc);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_beq_mispredict();
    drive(32'h100, 32'h40, 1, 0, 0, 3'b000, 0, 32'h104, 5'd0, 0, 32'h0, 1, 0);
    step();
    n_total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h140)
      $display("FAIL beq_redirect: got %b/%h want 1/00000140", redirect, redirect_pc);
    else n_pass++;
    n_total++;
    if (bp_upd_valid !== 1'b1 || bp_upd_taken !== 1'b1 || bp_upd_pc !== 32'h100 || mem_valid !== 1'b1)
      $display("FAIL beq_bp_mem: got bpv=%b tk=%b pc=%h mv=%b want 1 1 00000100 1",
               bp_upd_valid, bp_upd_taken, bp_upd_pc, mem_valid);
    else n_pass++;
    drive(32'h104, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd3, 1, 32'hDEAD, 0, 0);
    step();
    n_total++;
    if (mem_valid !== 1'b0 || mem_wb_en !== 1'b0 || redirect !== 1'b0 || bp_upd_valid !== 1'b0)
      $display("FAIL beq_squash: got mv=%b we=%b r=%b bp=%b want 0 0 0 0",
               mem_valid, mem_wb_en, redirect, bp_upd_valid);
    else n_pass++;
    drive(32'h140, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd4, 1, 32'h55, 0, 0);
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h55 || mem_rd !== 5'd4 || mem_wb_en !== 1'b1)
      $display("FAIL beq_resume: got mv=%b res=%h rd=%0d we=%b want 1 00000055 4 1",
               mem_valid, mem_result, mem_rd, mem_wb_en);
    else n_pass++;
  endtask

  task automatic test_bltu_not_taken();
    drive(32'h200, 32'h80, 1, 0, 0, 3'b110, 0, 32'h204, 5'd0, 0, 32'h1, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b0 || bp_upd_valid !== 1'b1 || bp_upd_taken !== 1'b0)
      $display("FAIL bltu_resolve: got r=%b bpv=%b tk=%b want 0 1 0", redirect, bp_upd_valid, bp_upd_taken);
    else n_pass++;
    n_total++;
    if (bp_upd_pc !== 32'h200 || bp_upd_target !== 32'h204)
      $display("FAIL bltu_bp_addr: got pc=%h tgt=%h want 00000200 00000204", bp_upd_pc, bp_upd_target);
    else n_pass++;
    // Reserved condition code with both flags set still resolves not taken.
    drive(32'h210, 32'h80, 1, 0, 0, 3'b010, 0, 32'h214, 5'd0, 0, 32'h0, 1, 1);
    step();
    n_total++;
    if (redirect !== 1'b0 || bp_upd_taken !== 1'b0 || bp_upd_valid !== 1'b1)
      $display("FAIL f3_010: got r=%b tk=%b bpv=%b want 0 0 1", redirect, bp_upd_taken, bp_upd_valid);
    else n_pass++;
  endtask

  task automatic test_jal_jalr();
    drive(32'h300, 32'h0, 0, 0, 1, 3'b000, 1, 32'h1234, 5'd1, 1, 32'h1235, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b0 || mem_result !== 32'h304 || mem_rd !== 5'd1 || mem_wb_en !== 1'b1)
      $display("FAIL jalr_hit: got r=%b res=%h rd=%0d we=%b want 0 00000304 1 1",
               redirect, mem_result, mem_rd, mem_wb_en);
    else n_pass++;
    drive(32'h300, 32'h0, 0, 0, 1, 3'b000, 1, 32'h1000, 5'd1, 1, 32'h1235, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h1234 || bp_upd_target !== 32'h1234)
      $display("FAIL jalr_miss: got r=%b rpc=%h tgt=%h want 1 00001234 00001234",
               redirect, redirect_pc, bp_upd_target);
    else n_pass++;
    drive(32'h304, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd2, 1, 32'h77, 0, 0);
    step();
    n_total++;
    if (mem_valid !== 1'b0 || redirect !== 1'b0)
      $display("FAIL jalr_squash: got mv=%b r=%b want 0 0", mem_valid, redirect);
    else n_pass++;
    // JAL with negative offset.
    drive(32'h400, 32'hFFFF_FFF8, 0, 1, 0, 3'b000, 1, 32'h3F8, 5'd1, 1, 32'h0, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b0 || mem_result !== 32'h404 || bp_upd_target !== 32'h3F8 || bp_upd_taken !== 1'b1)
      $display("FAIL jal_neg: got r=%b res=%h tgt=%h tk=%b want 0 00000404 000003f8 1",
               redirect, mem_result, bp_upd_target, bp_upd_taken);
    else n_pass++;
    // BNE target wraps modulo 2^32.
    drive(32'hFFFF_FFF0, 32'h20, 1, 0, 0, 3'b001, 1, 32'h10, 5'd0, 0, 32'h0, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b0 || bp_upd_target !== 32'h10 || bp_upd_taken !== 1'b1)
      $display("FAIL bne_wrap: got r=%b tgt=%h tk=%b want 0 00000010 1", redirect, bp_upd_target, bp_upd_taken);
    else n_pass++;
    // Predicted taken but to the wrong place: BLT taken, target mismatch.
    drive(32'h800, 32'h10, 1, 0, 0, 3'b100, 1, 32'h900, 5'd0, 0, 32'h0, 0, 1);
    step();
    n_total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h810)
      $display("FAIL blt_tgt_miss: got r=%b rpc=%h want 1 00000810", redirect, redirect_pc);
    else n_pass++;
    drive(32'h804, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd2, 1, 32'h1, 0, 0);
    step();
  endtask

  task automatic test_stall_after_mispredict();
    drive(32'h500, 32'h100, 1, 0, 0, 3'b101, 0, 32'h504, 5'd0, 0, 32'h77, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h600 || mem_valid !== 1'b1 || mem_result !== 32'h77)
      $display("FAIL bge_miss: got r=%b rpc=%h mv=%b res=%h want 1 00000600 1 00000077",
               redirect, redirect_pc, mem_valid, mem_result);
    else n_pass++;
    stall = 1'b1;
    drive(32'h504, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd9, 1, 32'hBAD, 0, 0);
    #1;
    n_total++;
    if (ex_ready !== 1'b0)
      $display("FAIL stall_ready: got %b want 0", ex_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (redirect !== 1'b0 || bp_upd_valid !== 1'b0 || mem_valid !== 1'b1 || mem_result !== 32'h77)
        $display("FAIL stall_hold_%0d: got r=%b bp=%b mv=%b res=%h want 0 0 1 00000077",
                 i, redirect, bp_upd_valid, mem_valid, mem_result);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_total++;
    if (mem_valid !== 1'b0 || bp_upd_valid !== 1'b0)
      $display("FAIL stall_squash: got mv=%b bp=%b want 0 0", mem_valid, bp_upd_valid);
    else n_pass++;
    drive(32'h600, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd6, 1, 32'h66, 0, 0);
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h66)
      $display("FAIL stall_resume: got mv=%b res=%h want 1 00000066", mem_valid, mem_result);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    flush = 1'b1;
    drive(32'h600, 32'h20, 1, 0, 0, 3'b001, 0, 32'h604, 5'd0, 0, 32'h0, 0, 0);
    step();
    n_total++;
    if (redirect !== 1'b0 || mem_valid !== 1'b0 || bp_upd_valid !== 1'b0)
      $display("FAIL flush_bne: got r=%b mv=%b bp=%b want 0 0 0", redirect, mem_valid, bp_upd_valid);
    else n_pass++;
    flush = 1'b0;
    drive(32'h700, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd7, 1, 32'h99, 0, 0);
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h99 || mem_rd !== 5'd7)
      $display("FAIL flush_next: got mv=%b res=%h rd=%0d want 1 00000099 7", mem_valid, mem_result, mem_rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_squash();
    drive(32'h100, 32'h40, 1, 0, 0, 3'b000, 0, 32'h104, 5'd0, 0, 32'h0, 1, 0);
    step();
    drive(32'h104, 32'h0, 0, 0, 0, 3'b000, 0, 32'h0, 5'd3, 1, 32'h33, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (redirect !== 1'b0 || mem_valid !== 1'b0 || bp_upd_valid !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL reset_async: got r=%b mv=%b bp=%b rpc=%h want 0 0 0 00000000",
               redirect, mem_valid, bp_upd_valid, redirect_pc);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    step();
    n_total++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h33 || mem_rd !== 5'd3)
      $display("FAIL reset_resume: got mv=%b res=%h rd=%0d want 1 00000033 3", mem_valid, mem_result, mem_rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bltu_not_taken();
    test_jal_jalr();
    test_stall_after_mispredict();
    test_flush_priority();
    test_reset_mid_squash();
    bubble();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
